// File: rtl/stage_seq_pkg.sv
// Shared constants and stage naming for the stage sequencer.
package stage_seq_pkg;

  // Canonical five-stage instruction flow.
  typedef enum logic [2:0] {
    ST_FT = 3'd0,
    ST_DC = 3'd1,
    ST_EX = 3'd2,
    ST_MA = 3'd3,
    ST_WB = 3'd4
  } stage_e;

  localparam int DEF_NUM_STAGES = 5;
  localparam int DEF_DIV_WIDTH  = 23;
  localparam int DEF_EX_STAGE   = int'(ST_EX);
  localparam int DEF_MA_STAGE   = int'(ST_MA);

endpackage

// File: rtl/step_div.sv
// Step divider: produces a one-cycle tick every div_ratio+1 cycles while
// free-running, or one tick the cycle after a step request while paused.
module step_div
  import stage_seq_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DIV_WIDTH-1:0] i_div_ratio,
  input  logic                 i_run,
  input  logic                 i_step_req,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_step_pend;
  logic                 w_div_hit;

  // A ratio lowered below the current count still hits, so the tick comes
  // on the next cycle instead of waiting for the counter to wrap.
  assign w_div_hit = i_run && (r_cnt >= i_div_ratio);
  assign o_tick    = w_div_hit || r_step_pend;

  // Count while running (frozen while paused); latch a step request for one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt       <= '0;
      r_step_pend <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_step_pend <= !i_run && i_step_req;
      if (i_run) begin
        r_cnt <= w_div_hit ? '0 : r_cnt + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/stage_seq.sv
// Stage sequencer: walks a one-hot stage enable through NUM_STAGES stages on
// each divider tick, holding the execute/memory stages while they are busy.
module stage_seq
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH,
  parameter int EX_STAGE   = DEF_EX_STAGE,
  parameter int MA_STAGE   = DEF_MA_STAGE
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DIV_WIDTH-1:0]          div_ratio,
  input  logic                          run,
  input  logic                          step_req,
  input  logic                          ex_busy,
  input  logic                          mem_wait,
  input  logic                          rw_mem,
  output logic [NUM_STAGES-1:0]         stage_en,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic                          stalled,
  output logic                          instr_done,
  output logic [31:0]                   retired
);

  localparam int IDX_W = $clog2(NUM_STAGES);

  logic                  w_tick;
  logic                  w_stall;
  logic                  w_last;
  logic [IDX_W-1:0]      r_idx;
  logic [NUM_STAGES-1:0] r_en;
  logic                  r_stalled;
  logic                  r_done;
  logic [31:0]           r_retired;

  step_div #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_step_div (
    .CLK         (CLK),
    .RST         (RST),
    .i_div_ratio (div_ratio),
    .i_run       (run),
    .i_step_req  (step_req),
    .o_tick      (w_tick)
  );

  assign w_last = (int'(r_idx) == NUM_STAGES - 1);

  // Hold condition for the active stage, evaluated in the tick cycle.
  always_comb begin
    // NOTE: default first so every path assigns w_stall and no latch is inferred.
    w_stall = 1'b0;
    if ((int'(r_idx) == EX_STAGE) && ex_busy) begin
      w_stall = 1'b1;
    end
    if ((int'(r_idx) == MA_STAGE) && rw_mem && mem_wait) begin
      w_stall = 1'b1;
    end
  end

  // Advance or hold the active stage on a tick; enables and done are one-cycle pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx     <= '0;
      r_en      <= '0;
      r_stalled <= 1'b0;
      r_done    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_en   <= '0;
      r_done <= 1'b0;
      if (w_tick) begin
        if (w_stall) begin
          r_stalled <= 1'b1;
        end else begin
          r_stalled <= 1'b0;
          r_en      <= NUM_STAGES'(1) << r_idx;
          if (w_last) begin
            r_idx     <= '0;
            r_done    <= 1'b1;
            r_retired <= r_retired + 32'd1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
      end
    end
  end

  assign stage_en   = r_en;
  assign stage_idx  = r_idx;
  assign stalled    = r_stalled;
  assign instr_done = r_done;
  assign retired    = r_retired;

endmodule

// File: tb/tb_stage_seq.sv
// Self-checking bench for stage_seq: directed scenarios plus a randomized
// phase, all compared each cycle against a behavioural reference model.
module tb_stage_seq;
  import stage_seq_pkg::*;

  localparam int N   = 5;
  localparam int DW  = 23;
  localparam int EXS = 2;
  localparam int MAS = 3;
  localparam int IW  = $clog2(N);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] div_ratio = '0;
  logic          run = 1'b0;
  logic          step_req = 1'b0;
  logic          ex_busy = 1'b0;
  logic          mem_wait = 1'b0;
  logic          rw_mem = 1'b0;
  logic [N-1:0]  stage_en;
  logic [IW-1:0] stage_idx;
  logic          stalled;
  logic          instr_done;
  logic [31:0]   retired;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  stage_seq #(
    .NUM_STAGES (N),
    .DIV_WIDTH  (DW),
    .EX_STAGE   (EXS),
    .MA_STAGE   (MAS)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .div_ratio  (div_ratio),
    .run        (run),
    .step_req   (step_req),
    .ex_busy    (ex_busy),
    .mem_wait   (mem_wait),
    .rw_mem     (rw_mem),
    .stage_en   (stage_en),
    .stage_idx  (stage_idx),
    .stalled    (stalled),
    .instr_done (instr_done),
    .retired    (retired)
  );

  // Reference model: elapsed running cycles since the last divider tick,
  // a pending single step, the current stage number and the retire count.
  int          m_elapsed;
  bit          m_pend;
  int          m_stage;
  bit          m_stalled;
  logic [31:0] m_retired;
  int          m_en_stage;
  bit          m_done;
  bit          m_tick;
  int          en_pulses;
  int          done_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_elapsed  = 0;
    m_pend     = 1'b0;
    m_stage    = 0;
    m_stalled  = 1'b0;
    m_retired  = '0;
    m_en_stage = -1;
    m_done     = 1'b0;
    m_tick     = 1'b0;
  endtask

  // Apply one clock edge's worth of behaviour using the inputs presented now.
  task automatic model_edge();
    bit div_hit;
    bit hold;
    div_hit = run && (m_elapsed >= int'(div_ratio));
    m_tick  = div_hit || m_pend;
    m_pend  = !run && step_req;
    if (run) m_elapsed = div_hit ? 0 : m_elapsed + 1;
    m_en_stage = -1;
    m_done     = 1'b0;
    if (m_tick) begin
      hold = ((m_stage == EXS) && ex_busy) || ((m_stage == MAS) && rw_mem && mem_wait);
      m_stalled = hold;
      if (!hold) begin
        m_en_stage = m_stage;
        if (m_stage == N - 1) begin
          m_done = 1'b1;
          m_retired = m_retired + 32'd1;
        end
        m_stage = (m_stage + 1) % N;
      end
    end
  endtask

  // One clock cycle: predict, clock, then compare every output #1 after the edge.
  task automatic cycle_chk();
    logic [31:0] exp_en;
    model_edge();
    @(posedge CLK);
    #1;
    exp_en = (m_en_stage < 0) ? 32'd0 : (32'd1 << m_en_stage);
    check("stage_en", 32'(stage_en), exp_en);
    check("stage_idx", 32'(stage_idx), 32'(m_stage));
    check("stalled", 32'(stalled), 32'(m_stalled));
    check("instr_done", 32'(instr_done), 32'(m_done));
    check("retired", retired, m_retired);
    check("onehot0", 32'($onehot0(stage_en)), 32'd1);
    if (stage_en != '0) en_pulses++;
    if (instr_done) done_pulses++;
  endtask

  task automatic run_until_tick(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      cycle_chk();
      got = m_tick;
    end
    check({tag, "_tick_reached"}, 32'(got), 32'd1);
  endtask

  initial begin
    int stall_ticks;
    int en_before;
    logic [31:0] exp_pat;

    // Reset state.
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_stage_en", 32'(stage_en), 32'd0);
    check("rst_stage_idx", 32'(stage_idx), 32'd0);
    check("rst_stalled", 32'(stalled), 32'd0);
    check("rst_instr_done", 32'(instr_done), 32'd0);
    check("rst_retired", retired, 32'd0);

    // Free-run at ratio 3: one enable every 4 cycles, one retire after 20.
    div_ratio = 3;
    run = 1'b1;
    RST = 1'b0;
    en_pulses = 0;
    done_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cycle_chk();
      exp_pat = (((i + 1) % 4) == 0) ? (32'd1 << (((i + 1) / 4 - 1) % N)) : 32'd0;
      check("ratio3_pattern", 32'(stage_en), exp_pat);
    end
    check("ratio3_retired", retired, 32'd1);
    check("ratio3_en_pulses", 32'(en_pulses), 32'd5);
    check("ratio3_done_pulses", 32'(done_pulses), 32'd1);

    // Execute stage held for three ticks by ex_busy.
    for (int i = 0; i < 10 && m_stage != EXS; i++) run_until_tick("to_ex");
    check("at_ex", 32'(stage_idx), 32'(EXS));
    ex_busy = 1'b1;
    stall_ticks = 0;
    for (int i = 0; i < 100 && stall_ticks < 3; i++) begin
      cycle_chk();
      if (m_tick) stall_ticks++;
      check("ex_hold_no_en", 32'(stage_en), 32'd0);
    end
    check("ex_stalled", 32'(stalled), 32'd1);
    check("ex_idx_held", 32'(stage_idx), 32'(EXS));
    ex_busy = 1'b0;
    run_until_tick("ex_release");
    check("ex_release_en", 32'(stage_en), 32'b00100);
    check("ex_release_stalled", 32'(stalled), 32'd0);

    // Memory stage: held only when the instruction accesses memory.
    rw_mem = 1'b1;
    mem_wait = 1'b1;
    run_until_tick("ma_hold1");
    run_until_tick("ma_hold2");
    check("ma_stalled", 32'(stalled), 32'd1);
    check("ma_idx_held", 32'(stage_idx), 32'(MAS));
    rw_mem = 1'b0;
    run_until_tick("ma_nomem");
    check("ma_nomem_en", 32'(stage_en), 32'b01000);
    check("ma_nomem_stalled", 32'(stalled), 32'd0);
    mem_wait = 1'b0;

    // Ratio lowered below the running count ticks on the next cycle.
    div_ratio = 20;
    run_until_tick("wb");
    repeat (7) cycle_chk();
    div_ratio = 2;
    cycle_chk();
    check("lowered_ratio_en", 32'(stage_en), 32'b00001);

    // Ratio 0: a tick every cycle.
    div_ratio = 0;
    for (int k = 0; k < N; k++) begin
      cycle_chk();
      exp_pat = 32'd1 << ((1 + k) % N);
      check("ratio0_en", 32'(stage_en), exp_pat);
    end

    // Paused single-stepping with a long ratio.
    run = 1'b0;
    div_ratio = 100;
    repeat (3) cycle_chk();
    en_before = en_pulses;
    for (int r = 0; r < 3; r++) begin
      step_req = 1'b1;
      cycle_chk();
      step_req = 1'b0;
      check("step_not_early", 32'(stage_en != '0), 32'd0);
      cycle_chk();
      check("step_en", 32'(stage_en != '0), 32'd1);
      repeat (3) cycle_chk();
    end
    repeat (20) cycle_chk();
    check("step_count", 32'(en_pulses - en_before), 32'd3);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      ex_busy  = ($urandom_range(0, 2) == 0);
      mem_wait = ($urandom_range(0, 1) == 0);
      rw_mem   = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      step_req = !step_req && ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) div_ratio = DW'($urandom_range(0, 4));
      cycle_chk();
    end

    // Asynchronous reset mid-count at stage 3 with a step pending.
    ex_busy = 1'b0;
    mem_wait = 1'b0;
    rw_mem = 1'b0;
    step_req = 1'b0;
    run = 1'b1;
    div_ratio = 5;
    for (int i = 0; i < 10 && m_stage != MAS; i++) run_until_tick("to_ma");
    cycle_chk();
    run = 1'b0;
    step_req = 1'b1;
    cycle_chk();
    step_req = 1'b0;
    #3;
    RST = 1'b1;
    #1;
    model_reset();
    check("arst_stage_en", 32'(stage_en), 32'd0);
    check("arst_stage_idx", 32'(stage_idx), 32'd0);
    check("arst_stalled", 32'(stalled), 32'd0);
    check("arst_instr_done", 32'(instr_done), 32'd0);
    check("arst_retired", retired, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (3) cycle_chk();
    check("arst_pend_cleared", 32'(stage_en), 32'd0);

    // Retire counter wraps from all-ones to zero.
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    m_retired = 32'hFFFF_FFFF;
    run = 1'b1;
    div_ratio = 0;
    done_pulses = 0;
    repeat (N) cycle_chk();
    check("wrap_retired", retired, 32'd0);
    check("wrap_done", 32'(done_pulses), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_seq.md
STAGE_SEQ -- requirements
Module: stage_seq

Interface
REQ-001 Parameter NUM_STAGES, default 5, number of pipeline-sequence stages (range 2..16).
REQ-002 Parameter DIV_WIDTH, default 23, width of the step-divider ratio.
REQ-003 Parameter EX_STAGE, default 2, stage index that stalls on ex_busy.
REQ-004 Parameter MA_STAGE, default 3, stage index that stalls on mem_wait.
REQ-005 CLK  in  1  sole clock; all state on rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 div_ratio  in  DIV_WIDTH  a stage step occurs every div_ratio+1 CLK cycles.
REQ-008 run  in  1  1 = free-running; 0 = paused, single-step only.
REQ-009 step_req  in  1  one-cycle pulse; requests one tick while run=0.
REQ-010 ex_busy  in  1  execute unit busy; holds EX_STAGE.
REQ-011 mem_wait  in  1  memory not ready; holds MA_STAGE when rw_mem=1.
REQ-012 rw_mem  in  1  current instruction accesses memory.
REQ-013 stage_en  out  NUM_STAGES  one-hot, one-CLK-cycle clock-enable for the completing stage.
REQ-014 stage_idx  out  $clog2(NUM_STAGES)  currently active stage.
REQ-015 stalled  out  1  active stage held on the last tick.
REQ-016 instr_done  out  1  one-cycle pulse when the last stage completes.
REQ-017 retired  out  32  completed-instruction count.

Function
REQ-018 Divider counts 0 upward while run=1; tick when count >= div_ratio, count returns to 0 on the tick cycle.
REQ-019 div_ratio=0 SHALL give a tick every CLK cycle; a ratio lowered mid-count below the current count SHALL tick on the next cycle.
REQ-020 run=0: divider frozen at its value; a step_req SHALL produce exactly one tick one cycle later; step_req while run=1 is ignored.
REQ-021 Stall on a tick: (stage_idx==EX_STAGE and ex_busy) or (stage_idx==MA_STAGE and rw_mem and mem_wait), sampled in the tick cycle.
REQ-022 Tick, no stall: stage_en[stage_idx]=1 for that cycle, stage_idx advances by 1 registered, stalled<=0.
REQ-023 Tick with stall: stage_en all 0, stage_idx unchanged, stalled<=1; re-evaluated on each following tick.
REQ-024 stage_idx==NUM_STAGES-1 completing SHALL wrap to 0, pulse instr_done in the same cycle as stage_en[NUM_STAGES-1], and increment retired.
REQ-025 retired SHALL wrap from 2^32-1 to 0 without flag.
REQ-026 No tick: stage_en=0, instr_done=0, stage_idx and stalled hold.
REQ-027 stage_en and instr_done SHALL be registered outputs, never gated clocks; at most one stage_en bit high in any cycle.

Reset
REQ-028 RST asserted (any time, mid-stall or mid-count): divider count 0, stage_idx 0, stage_en 0, stalled 0, instr_done 0, retired 0, pending step cleared.
REQ-029 First tick after RST release with run=1 SHALL occur div_ratio+1 cycles after the first active edge.

Structure
REQ-030 Package stage_seq_pkg holds default parameter constants and a 5-stage index enum (ST_FT=0, ST_DC, ST_EX, ST_MA, ST_WB).
REQ-031 Divider and step logic in sub-module step_div (outputs tick), instantiated once.

Verification
REQ-032 div_ratio=3, run=1, no stalls -> stage_en 00001,00010,...,10000 every 4 cycles; instr_done with 10000; retired=1 after 20 cycles.
REQ-033 ex_busy=1 at stage 2 for 3 ticks -> stalled=1, no stage_en for 3 ticks, then stage_en=00100 on the 4th.
REQ-034 rw_mem=1, mem_wait=1 at stage 3 -> held; rw_mem=0, mem_wait=1 -> no stall, stage_en=01000.
REQ-035 run=0, three step_req pulses, div_ratio=100 -> exactly three stage_en pulses, each one cycle after its request.
REQ-036 RST asserted at stage 3 mid-count -> all outputs 0 asynchronously; retired 0xFFFFFFFF preload then one instruction -> 0.
